// File: rtl/p2s_arbiter.sv
// p2s_arbiter: round-robin arbiter feeding one LSB-first parallel-to-serial shifter
module p2s_arbiter #(
  parameter int NREQ       = 4,
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1,
  parameter int ID_W       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  ser_out,
  output logic                  ser_frame,
  output logic [ID_W-1:0]       ser_id,
  output logic                  busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t          state, nxt;
  logic [ID_W-1:0] ptr, win;
  logic [ID_W:0]   j;
  logic            hit, xfer, last_bit, last_gap;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]   cnt;
  logic [3:0]      gcnt;
  // scan requesters from ptr upward with wrap; first valid one wins
  always_comb begin
    win = '0;
    hit = 1'b0;
    j   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = {1'b0, ptr} + (ID_W+1)'(k);
      if (j >= (ID_W+1)'(NREQ)) j = j - (ID_W+1)'(NREQ);
      if (!hit && req_valid[j[ID_W-1:0]]) begin
        hit = 1'b1;
        win = j[ID_W-1:0];
      end
    end
  end
  assign xfer      = (state == IDLE) && hit && !rst;
  assign req_ready = xfer ? (NREQ'(1) << win) : '0;
  assign last_bit  = cnt == CW'(WIDTH - 1);
  assign last_gap  = gcnt == 4'(GAP_CYCLES - 1);
  assign ser_frame = state == SHIFT;
  assign ser_out   = (state == SHIFT) & sr[0];
  assign busy      = (state == SHIFT) || (state == GAP);
  // next-state selection; unused encodings fall back to IDLE
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = hit ? SHIFT : IDLE;
      SHIFT:   nxt = last_bit ? ((GAP_CYCLES == 0) ? IDLE : GAP) : SHIFT;
      GAP:     nxt = last_gap ? IDLE : GAP;
      default: nxt = IDLE;
    endcase
  end
  // state, pointer, shifter and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      sr     <= '0;
      cnt    <= '0;
      gcnt   <= '0;
      ser_id <= '0;
    end else begin
      state <= nxt;
      if (xfer) begin
        sr     <= req_data[win*WIDTH +: WIDTH];
        ser_id <= win;
        ptr    <= (win == ID_W'(NREQ - 1)) ? '0 : win + 1'b1;
        cnt    <= '0;
      end else if (state == SHIFT) begin
        sr  <= {1'b0, sr[WIDTH-1:1]};
        cnt <= cnt + 1'b1;
      end
      gcnt <= (state == GAP) ? gcnt + 1'b1 : '0;
    end
  end
endmodule
